// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - switch-and-key instruction memory loader
//
// prog_loader_key: 2-flop synchronizer + debouncer for one active-low pushbutton.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_raw    : raw pushbutton level (0 = pressed)
//   press      : one-cycle pulse on each debounced 1->0 transition
//
// prog_loader: assembles two operator-entered bytes into an instruction word
// and writes it to memory; holds the processor in reset until a Run request.
//   Clk, Reset           : clock, asynchronous active-low reset
//   KEY_Byte/Addr/Run    : raw active-low pushbuttons
//   Byte_In, Addr_In     : switch inputs (byte value, start address)
//   Mem_WrEn/Addr/Data   : instruction memory write port
//   CPU_Run              : processor released from reset
//   Word_Count           : words written since reset, saturating at 2^ADDR_W
//   Load_State           : FSM state for display

module prog_loader_key #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);
  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= 1'b0;
      // The current sample is the CYCLES-th consecutive differing one when
      // the counter already holds CYCLES-1; any agreeing sample restarts it.
      if (sync2 != level) begin
        if (cnt == CW'(CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module prog_loader #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              KEY_Byte,
  input  logic              KEY_Addr,
  input  logic              KEY_Run,
  input  logic [7:0]        Byte_In,
  input  logic [ADDR_W-1:0] Addr_In,
  output logic              Mem_WrEn,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              CPU_Run,
  output logic [ADDR_W:0]   Word_Count,
  output logic [1:0]        Load_State
);
  typedef enum logic [1:0] {
    LOADHI = 2'd0,
    LOADLO = 2'd1,
    WRITE  = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic press_byte;
  logic press_addr;
  logic press_run;

  prog_loader_key #(.CYCLES(DEBOUNCE_CYCLES)) u_key_byte (
    .clk(Clk), .rst_n(Reset), .key_raw(KEY_Byte), .press(press_byte)
  );
  prog_loader_key #(.CYCLES(DEBOUNCE_CYCLES)) u_key_addr (
    .clk(Clk), .rst_n(Reset), .key_raw(KEY_Addr), .press(press_addr)
  );
  prog_loader_key #(.CYCLES(DEBOUNCE_CYCLES)) u_key_run (
    .clk(Clk), .rst_n(Reset), .key_raw(KEY_Run), .press(press_run)
  );

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;
  logic [ADDR_W:0]   count_nx;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= LOADHI;
      Mem_Addr   <= '0;
      Mem_Data   <= '0;
      Word_Count <= '0;
      CPU_Run    <= 1'b0;
    end else begin
      state      <= state_nx;
      Mem_Addr   <= addr_nx;
      Mem_Data   <= data_nx;
      Word_Count <= count_nx;
      CPU_Run    <= (state_nx == RUN);
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = Mem_Addr;
    data_nx  = Mem_Data;
    count_nx = Word_Count;
    case (state)
      LOADHI: begin
        if (press_run) begin
          state_nx = RUN;
        end else if (press_addr) begin
          addr_nx = Addr_In;
        end else if (press_byte) begin
          data_nx[DATA_W-1 -: 8] = Byte_In;
          state_nx = LOADLO;
        end
      end
      LOADLO: begin
        if (press_addr) begin
          data_nx  = '0;
          addr_nx  = Addr_In;
          state_nx = LOADHI;
        end else if (press_byte) begin
          data_nx[7:0] = Byte_In;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        // Presses landing in this cycle are intentionally dropped.
        addr_nx = Mem_Addr + ADDR_W'(1);
        if (Word_Count != COUNT_MAX) begin
          count_nx = Word_Count + (ADDR_W + 1)'(1);
        end
        state_nx = LOADHI;
      end
      RUN: begin
        if (press_run) begin
          state_nx = LOADHI;
        end
      end
      default: state_nx = LOADHI;
    endcase
  end

  // Decoded from the state register so a reset drops it without a clock.
  assign Mem_WrEn   = (state == WRITE);
  assign Load_State = state;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;
  localparam int DB = 4;

  logic        Clk;
  logic        Reset;
  logic        KEY_Byte;
  logic        KEY_Addr;
  logic        KEY_Run;
  logic [7:0]  Byte_In;
  logic [7:0]  Addr_In;
  logic        Mem_WrEn;
  logic [7:0]  Mem_Addr;
  logic [15:0] Mem_Data;
  logic        CPU_Run;
  logic [8:0]  Word_Count;
  logic [1:0]  Load_State;

  int n_checks = 0;
  int n_errors = 0;
  int wr_pulses = 0;

  logic [1:0]  st_before, st_after;
  logic [7:0]  addr_before, addr_after;
  logic [15:0] data_before, data_after;
  logic        wren_after, run_after;

  prog_loader #(.ADDR_W(8), .DATA_W(16), .DEBOUNCE_CYCLES(DB)) dut (
    .Clk(Clk), .Reset(Reset),
    .KEY_Byte(KEY_Byte), .KEY_Addr(KEY_Addr), .KEY_Run(KEY_Run),
    .Byte_In(Byte_In), .Addr_In(Addr_In),
    .Mem_WrEn(Mem_WrEn), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
    .CPU_Run(CPU_Run), .Word_Count(Word_Count), .Load_State(Load_State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Mem_WrEn) wr_pulses++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: KEY_Byte = v;
      1: KEY_Addr = v;
      default: KEY_Run = v;
    endcase
  endtask

  // Edge t is the first posedge after the key goes low; snapshots are taken
  // just after edge t+1+DB (no change yet) and edge t+2+DB (update visible).
  task automatic press_key(input int k);
    @(negedge Clk);
    set_key(k, 1'b0);
    repeat (2 + DB) @(posedge Clk);
    #1;
    st_before = Load_State; addr_before = Mem_Addr; data_before = Mem_Data;
    @(posedge Clk);
    #1;
    st_after = Load_State; addr_after = Mem_Addr; data_after = Mem_Data;
    wren_after = Mem_WrEn; run_after = CPU_Run;
    repeat (3) @(negedge Clk);
    set_key(k, 1'b1);
    repeat (DB + 5) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0; KEY_Byte = 1'b1; KEY_Addr = 1'b1; KEY_Run = 1'b1;
    Byte_In = 8'h00; Addr_In = 8'h00;

    // Reset held with keys chattering
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      KEY_Byte = 1'($urandom_range(1)); KEY_Addr = 1'($urandom_range(1));
      KEY_Run  = 1'($urandom_range(1));
    end
    #1;
    check_val("rst_wren", Mem_WrEn, 0);
    check_val("rst_addr", Mem_Addr, 0);
    check_val("rst_data", Mem_Data, 0);
    check_val("rst_run", CPU_Run, 0);
    check_val("rst_count", Word_Count, 0);
    check_val("rst_state", Load_State, 0);
    @(negedge Clk);
    KEY_Byte = 1'b1; KEY_Addr = 1'b1; KEY_Run = 1'b1;
    Reset = 1'b1;
    repeat (20) @(negedge Clk);
    check_val("post_rst_wr", wr_pulses, 0);
    check_val("post_rst_state", Load_State, 0);

    // Single word at 0x10
    Addr_In = 8'h10;
    press_key(1);
    check_val("w1_addr_lat_before", addr_before, 8'h00);
    check_val("w1_addr_lat_after", addr_after, 8'h10);
    Byte_In = 8'hA5;
    press_key(0);
    check_val("w1_hi_lat_before", st_before, 0);
    check_val("w1_hi_state", st_after, 1);
    check_val("w1_hi_data", data_after, 16'hA500);
    Byte_In = 8'h3C;
    press_key(0);
    check_val("w1_lo_lat_before", st_before, 1);
    check_val("w1_lo_state", st_after, 2);
    check_val("w1_lo_wren", wren_after, 1);
    check_val("w1_lo_addr", addr_after, 8'h10);
    check_val("w1_lo_data", data_after, 16'hA53C);
    check_val("w1_next_addr", Mem_Addr, 8'h11);
    check_val("w1_count", Word_Count, 1);
    check_val("w1_state", Load_State, 0);
    check_val("w1_pulses", wr_pulses, 1);

    // Bounce rejection: three glitches of DB-1 sampled lows
    Byte_In = 8'h11;
    for (int g = 0; g < 3; g++) begin
      @(negedge Clk);
      KEY_Byte = 1'b0;
      repeat (DB - 1) @(negedge Clk);
      KEY_Byte = 1'b1;
      repeat (DB + 3) @(negedge Clk);
    end
    check_val("bounce_state", Load_State, 0);
    check_val("bounce_data", Mem_Data, 16'hA53C);
    press_key(0);
    check_val("clean_state", st_after, 1);
    check_val("clean_data", data_after, 16'h113C);
    check_val("clean_once", Load_State, 1);

    // Abort from LOADLO to address 0xFF, then wrap write
    Addr_In = 8'hFF;
    press_key(1);
    check_val("abort1_state", st_after, 0);
    check_val("abort1_data", data_after, 16'h0000);
    check_val("abort1_addr", addr_after, 8'hFF);
    Byte_In = 8'h12; press_key(0);
    Byte_In = 8'h34; press_key(0);
    check_val("wrap_wren", wren_after, 1);
    check_val("wrap_wr_addr", addr_after, 8'hFF);
    check_val("wrap_wr_data", data_after, 16'h1234);
    check_val("wrap_addr", Mem_Addr, 8'h00);
    check_val("wrap_count", Word_Count, 2);
    Byte_In = 8'h77; press_key(0);
    check_val("abort2_hi", data_after, 16'h7734);
    Addr_In = 8'h05; press_key(1);
    check_val("abort2_data", Mem_Data, 16'h0000);
    check_val("abort2_addr", Mem_Addr, 8'h05);
    check_val("abort2_state", Load_State, 0);
    check_val("abort2_pulses", wr_pulses, 2);

    // Run toggle
    press_key(2);
    check_val("run_state", st_after, 3);
    check_val("run_cpu", run_after, 1);
    Byte_In = 8'h9A; press_key(0);
    Addr_In = 8'h40; press_key(1);
    check_val("run_ign_state", Load_State, 3);
    check_val("run_ign_addr", Mem_Addr, 8'h05);
    check_val("run_ign_data", Mem_Data, 16'h0000);
    press_key(2);
    check_val("stop_state", st_after, 0);
    check_val("stop_cpu", run_after, 0);
    check_val("stop_addr", Mem_Addr, 8'h05);
    press_key(0);
    check_val("lo_state", st_after, 1);
    press_key(2);
    check_val("lo_run_ign_state", Load_State, 1);
    check_val("lo_run_ign_cpu", CPU_Run, 0);

    // Reset during the WRITE cycle
    Byte_In = 8'h55;
    @(negedge Clk);
    KEY_Byte = 1'b0;
    repeat (3 + DB) @(posedge Clk);
    #1;
    check_val("mid_wren_hi", Mem_WrEn, 1);
    #1;
    Reset = 1'b0;
    #1;
    check_val("mid_wren_lo", Mem_WrEn, 0);
    check_val("mid_count", Word_Count, 0);
    check_val("mid_addr", Mem_Addr, 0);
    check_val("mid_state", Load_State, 0);
    @(negedge Clk);
    KEY_Byte = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (DB + 6) @(negedge Clk);
    check_val("mid_pulses", wr_pulses, 2);
    check_val("mid_after_state", Load_State, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Switch-and-key program loader for the board-level processor build. It is the write side of the instruction memory: the board display path reads processor state out to the HEX digits, and this block pushes operator-entered 16-bit instruction words into memory. An operator enters each word as two bytes on SW[7:0], using debounced KEY presses. The block holds the processor in reset while loading and releases it on a Run request.

## Interface
Parameters:
- ADDR_W, 8, instruction memory address width
- DATA_W, 16, instruction word width (two 8-bit bytes)
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a key level change (board build overrides to ~500000)

Ports:
- Clk  input  1  system clock; single clock domain
- Reset  input  1  asynchronous, active-low; clears all state
- KEY_Byte  input  1  raw pushbutton, active-low; enter next byte
- KEY_Addr  input  1  raw pushbutton, active-low; load start address
- KEY_Run  input  1  raw pushbutton, active-low; toggle load/run
- Byte_In  input  8  byte value from SW[7:0]
- Addr_In  input  ADDR_W  start address from SW[15:8]
- Mem_WrEn  output  1  one-cycle instruction-memory write strobe
- Mem_Addr  output  ADDR_W  write address
- Mem_Data  output  DATA_W  write data
- CPU_Run  output  1  high = processor released from reset
- Word_Count  output  ADDR_W+1  words written since reset; saturates at 2^ADDR_W
- Load_State  output  2  FSM state for HEX display

## Operation
Key conditioning:
- Each key passes through a 2-flop synchronizer, then a debouncer.
- The debouncer holds a level that starts at released (1). It flips only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from the held level. Any differing run shorter than that resets the counter.
- A press event is a one-cycle pulse on the debounced 1→0 transition. A release produces no event.

FSM states (Load_State encoding): LOADHI=0, LOADLO=1, WRITE=2, RUN=3.
- **LOADHI**
  - Priority is Run > Addr > Byte.
  - Run press → RUN.
  - Addr press → Mem_Addr <= Addr_In; stay in LOADHI.
  - Byte press → Mem_Data[15:8] <= Byte_In; go to LOADLO.
- **LOADLO**
  - Addr press → discard the partial word: Mem_Data <= 0, Mem_Addr <= Addr_In; go to LOADHI.
  - Otherwise, Byte press → Mem_Data[7:0] <= Byte_In; go to WRITE.
  - Run press is ignored.
- **WRITE**
  - Mem_WrEn = 1 for exactly this one cycle; Mem_Addr and Mem_Data are stable throughout.
  - On exit: Mem_Addr increments, wrapping from 2^ADDR_W−1 to 0. Word_Count increments, saturating. Go to LOADHI.
  - All press events arriving in this cycle are dropped.
- **RUN**
  - CPU_Run = 1.
  - Run press → CPU_Run = 0; go to LOADHI with Mem_Addr and Word_Count unchanged.
  - Byte and Addr presses are ignored.
- CPU_Run is a registered output, high only in RUN. Mem_WrEn is high only in WRITE.

## Timing
- Reset values:
  - State = LOADHI.
  - Mem_WrEn = 0, Mem_Addr = 0, Mem_Data = 0, CPU_Run = 0, Word_Count = 0.
  - Synchronizers and debounced levels = 1 (released); debounce counters = 0.
- Reset asserted mid-operation (including during WRITE or RUN) returns everything to the reset values immediately. A WRITE in progress is aborted, and Mem_WrEn drops asynchronously.
- Key latency:
  - Let edge t be the first Clk edge that samples the raw key low.
  - The press-event pulse is high in the cycle following edge t+1+DEBOUNCE_CYCLES.
  - The FSM acts on that pulse at the next edge, so the state/register update is visible after edge t+2+DEBOUNCE_CYCLES.
- Byte to strobe: Mem_WrEn rises one cycle after the LO-byte press is accepted, lasts exactly 1 cycle, and Mem_Addr updates on the edge that ends it.
- Held key: generates exactly one event per press/release cycle, no auto-repeat.
- Simultaneous events: the priorities above apply. A key pressed and released inside the debounce window generates no event.

## Test plan
- **Reset:** hold Reset=0 with random keys toggling → all outputs 0, Load_State=0. Release Reset → no spurious Mem_WrEn or events.
- **Single word:**
  - Stimulus: Addr_In=0x10, press KEY_Addr; Byte_In=0xA5, press KEY_Byte; Byte_In=0x3C, press KEY_Byte.
  - Response: exactly one Mem_WrEn pulse with Mem_Addr=0x10, Mem_Data=0xA53C. Then Mem_Addr=0x11, Word_Count=1, each key latency exactly t+2+DEBOUNCE_CYCLES.
- **Bounce rejection:** KEY_Byte glitches low for DEBOUNCE_CYCLES−1 cycles, three times → no event, state stays LOADHI. A following clean press is accepted once.
- **Wrap and abort:**
  - Set address 0xFF and write word 0x1234 → write lands at 0xFF, then Mem_Addr=0x00.
  - Then enter hi byte 0x77 and press KEY_Addr with Addr_In=0x05 → no write, Mem_Data=0, Mem_Addr=0x05, Load_State=0.
- **Run toggle:**
  - Press KEY_Run in LOADHI → CPU_Run=1, Load_State=3. KEY_Byte/KEY_Addr presses have no effect.
  - Press KEY_Run again → CPU_Run=0, Load_State=0, Mem_Addr unchanged.
  - Press KEY_Run while in LOADLO → ignored.
- **Mid-operation reset:** assert Reset=0 during the WRITE cycle → Mem_WrEn falls without waiting for Clk, Word_Count=0, Mem_Addr=0.
